// File: rtl/dmem_mmio_if.sv
// dmem_mmio_if: core data-side load/store bus
interface dmem_mmio_if;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    modport master (output MemWrite, DataAdr, WriteData, input ReadData);
    modport slave  (input MemWrite, DataAdr, WriteData, output ReadData);
endinterface

// File: rtl/dmem_mmio.sv
// dmem_mmio: word RAM plus GPIO/timer/cycle-counter MMIO page with combinational reads
module dmem_mmio #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] MMIO_BASE = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        reset,
    dmem_mmio_if.slave  bus,
    output logic [31:0] GPIOOut,
    output logic        TimerFlag
);
    localparam int AW = $clog2(DEPTH);
    logic [31:0]   ram_q [DEPTH];
    logic [31:0]   gpio_q, gpio_d, cnt_q, cnt_d, cmp_q, cmp_d, cyc_q, cyc_d;
    logic [1:0]    ctrl_q, ctrl_d;
    logic          sts_q, sts_d;
    logic          ram_sel, mmio_sel, wr, match;
    logic [5:0]    off;
    logic [AW-1:0] widx;
    // address decode, register next-state and read mux
    always_comb begin
        ram_sel      = bus.DataAdr < 32'(DEPTH * 4);
        mmio_sel     = !ram_sel && bus.DataAdr[31:8] == MMIO_BASE[31:8];
        wr           = bus.MemWrite && mmio_sel;
        off          = bus.DataAdr[7:2];
        widx         = bus.DataAdr[AW+1:2];
        match        = ctrl_q[0] && cnt_q == cmp_q;
        gpio_d       = (wr && off == 6'd0) ? bus.WriteData : gpio_q;
        cnt_d        = (wr && off == 6'd1) ? bus.WriteData :
                       !ctrl_q[0] ? cnt_q :
                       (match && ctrl_q[1]) ? 32'd0 : cnt_q + 32'd1;
        cmp_d        = (wr && off == 6'd2) ? bus.WriteData : cmp_q;
        ctrl_d       = (wr && off == 6'd3) ? bus.WriteData[1:0] : ctrl_q;
        sts_d        = match || (sts_q && !(wr && off == 6'd4 && bus.WriteData[0]));
        cyc_d        = cyc_q + 32'd1;
        bus.ReadData = ram_sel ? ram_q[widx] :
                       !mmio_sel ? 32'd0 :
                       off == 6'd0 ? gpio_q :
                       off == 6'd1 ? cnt_q :
                       off == 6'd2 ? cmp_q :
                       off == 6'd3 ? {30'd0, ctrl_q} :
                       off == 6'd4 ? {31'd0, sts_q} :
                       off == 6'd5 ? cyc_q : 32'd0;
        GPIOOut      = gpio_q;
        TimerFlag    = sts_q;
    end
    // MMIO registers and counters, reset has priority over stores
    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_q <= '0;
            cnt_q  <= '0;
            cmp_q  <= '0;
            ctrl_q <= '0;
            sts_q  <= 1'b0;
            cyc_q  <= '0;
        end else begin
            gpio_q <= gpio_d;
            cnt_q  <= cnt_d;
            cmp_q  <= cmp_d;
            ctrl_q <= ctrl_d;
            sts_q  <= sts_d;
            cyc_q  <= cyc_d;
        end
    end
    // RAM store port, contents survive reset
    always_ff @(posedge clk) begin
        if (bus.MemWrite && ram_sel && !reset) ram_q[widx] <= bus.WriteData;
    end
endmodule
